// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM state type and single-bit subtract equations for serial and parallel subtractors
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bin);
    return {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit d = a - b - bin with borrow out bout (ports a, b, bin -> d, bout)
module full_subtractor
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign {bout, d} = sub_bit(a, b, bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - borrow_in (start/a/b/borrow_in in; busy/done/diff/borrow_out/ovf/ser_diff/ser_valid out)
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             ser_diff,
  output logic             ser_valid
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_n;
  logic [CW-1:0] cnt;
  logic br, a_msb, b_msb, d, bout, accept, last;
  assign accept = start && state != RUN;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign res_n = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
  full_subtractor u_fs (.a(a_sh[0]), .b(b_sh[0]), .bin(br), .d(d), .bout(bout));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res <= '0;
      cnt <= '0;
      br <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff <= '0;
      borrow_out <= 1'b0;
      ovf <= 1'b0;
      ser_diff <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      ser_valid <= state == RUN;
      ser_diff <= state == RUN && d;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        br <= borrow_in;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        cnt <= '0;
        res <= '0;
      end else if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        br <= bout;
        res <= res_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          diff <= res_n;
          borrow_out <= bout;
          ovf <= (a_msb != b_msb) && (d != a_msb);
        end
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed-vector self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1
module tb_serial_subtractor;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, borrow_in = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic busy, done, borrow_out, ovf, ser_diff, ser_valid;
  logic start1 = 1'b0, bi1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic busy1, done1, bo1, ovf1, sd1, sv1;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .borrow_in(borrow_in), .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .ovf(ovf), .ser_diff(ser_diff), .ser_valid(ser_valid));
  serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .borrow_in(bi1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1),
    .ovf(ovf1), .ser_diff(sd1), .ser_valid(sv1));
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibi,
                        output int lat, output logic [7:0] stream, output logic post_done);
    int k;
    @(negedge clk);
    a = ia; b = ib; borrow_in = ibi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; stream = '0; k = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (ser_valid && k < 8) begin stream[k] = ser_diff; k++; end
      if (done) break;
      lat++;
    end
    @(negedge clk);
    post_done = done;
  endtask
  task automatic test_reset();
    #3;
    vecs++;
    if ({busy, done, diff, borrow_out, ovf, ser_diff, ser_valid} !== 14'h0) begin
      errs++; $display("FAIL reset8 got %h required 0", {busy, done, diff, borrow_out, ovf, ser_diff, ser_valid});
    end
    vecs++;
    if ({busy1, done1, diff1, bo1, ovf1, sd1, sv1} !== 7'h0) begin
      errs++; $display("FAIL reset1 got %h required 0", {busy1, done1, diff1, bo1, ovf1, sd1, sv1});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    int lat; logic [7:0] s; logic pd;
    run_op(8'h5A, 8'h3C, 1'b0, lat, s, pd);
    vecs++; if (s !== 8'h1E) begin errs++; $display("FAIL basic_stream got %h required 1e", s); end
    vecs++; if (lat !== 8) begin errs++; $display("FAIL basic_latency got %0d required 8", lat); end
    vecs++; if (diff !== 8'h1E) begin errs++; $display("FAIL basic_diff got %h required 1e", diff); end
    vecs++; if ({borrow_out, ovf} !== 2'b00) begin errs++; $display("FAIL basic_flags got %b required 00", {borrow_out, ovf}); end
    vecs++; if (pd !== 1'b0) begin errs++; $display("FAIL basic_done_width got %b required 0", pd); end
  endtask
  task automatic test_borrow();
    int lat; logic [7:0] s; logic pd;
    run_op(8'h00, 8'h01, 1'b0, lat, s, pd);
    vecs++; if (diff !== 8'hFF) begin errs++; $display("FAIL borrow1_diff got %h required ff", diff); end
    vecs++; if ({borrow_out, ovf} !== 2'b10) begin errs++; $display("FAIL borrow1_flags got %b required 10", {borrow_out, ovf}); end
    run_op(8'h10, 8'h0F, 1'b1, lat, s, pd);
    vecs++; if (diff !== 8'h00) begin errs++; $display("FAIL borrow2_diff got %h required 00", diff); end
    vecs++; if (borrow_out !== 1'b0) begin errs++; $display("FAIL borrow2_bout got %b required 0", borrow_out); end
  endtask
  task automatic test_overflow();
    int lat; logic [7:0] s; logic pd;
    run_op(8'h80, 8'h01, 1'b0, lat, s, pd);
    vecs++; if (diff !== 8'h7F) begin errs++; $display("FAIL ovf1_diff got %h required 7f", diff); end
    vecs++; if ({borrow_out, ovf} !== 2'b01) begin errs++; $display("FAIL ovf1_flags got %b required 01", {borrow_out, ovf}); end
    run_op(8'h7F, 8'hFF, 1'b0, lat, s, pd);
    vecs++; if (diff !== 8'h80) begin errs++; $display("FAIL ovf2_diff got %h required 80", diff); end
    vecs++; if ({borrow_out, ovf} !== 2'b11) begin errs++; $display("FAIL ovf2_flags got %b required 11", {borrow_out, ovf}); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] oa [3] = '{8'h33, 8'h05, 8'h40};
    logic [7:0] ob [3] = '{8'h11, 8'h07, 8'h20};
    logic       obi[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] ex [3] = '{8'h22, 8'hFE, 8'h1F};
    int n = 0, last_t = -1;
    logic prev = 1'b0;
    @(negedge clk);
    a = oa[0]; b = ob[0]; borrow_in = obi[0]; start = 1'b1;
    for (int t = 0; t < 60 && n < 3; t++) begin
      @(negedge clk);
      if (done) begin
        vecs++; if (diff !== ex[n]) begin errs++; $display("FAIL b2b_diff%0d got %h required %h", n, diff, ex[n]); end
        if (n > 0) begin
          vecs++; if (t - last_t !== 9) begin errs++; $display("FAIL b2b_gap%0d got %0d required 9", n, t - last_t); end
        end
        vecs++; if (prev !== 1'b0) begin errs++; $display("FAIL b2b_done_width%0d got 2 cycles required 1", n); end
        last_t = t; n++;
        if (n < 3) begin a = oa[n]; b = ob[n]; borrow_in = obi[n]; end
        else start = 1'b0;
      end else if (busy) begin
        a = 8'hFF; b = 8'hFF; borrow_in = 1'b1;
      end
      prev = done;
    end
    start = 1'b0;
    vecs++; if (n !== 3) begin errs++; $display("FAIL b2b_count got %0d required 3", n); end
    @(negedge clk);
    vecs++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL b2b_idle got %b required 00", {busy, done}); end
  endtask
  task automatic test_mid_run_start();
    int n = 0;
    @(negedge clk);
    a = 8'h90; b = 8'h10; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h01; b = 8'h02; borrow_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done) n++;
    end
    vecs++; if (n !== 1) begin errs++; $display("FAIL mid_start_dones got %0d required 1", n); end
    vecs++; if ({diff, borrow_out, ovf} !== {8'h80, 2'b00}) begin
      errs++; $display("FAIL mid_start_result got %h/%b%b required 80/00", diff, borrow_out, ovf);
    end
  endtask
  task automatic test_reset_mid_run();
    int n = 0, lat; logic [7:0] s; logic pd;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy, done, diff, borrow_out, ovf, ser_diff, ser_valid} !== 14'h0) begin
      errs++; $display("FAIL midreset_outputs got %h required 0", {busy, done, diff, borrow_out, ovf, ser_diff, ser_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    vecs++; if (n !== 0) begin errs++; $display("FAIL midreset_no_done got %0d active cycles required 0", n); end
    run_op(8'h5A, 8'h3C, 1'b0, lat, s, pd);
    vecs++; if ({diff, lat[3:0]} !== {8'h1E, 4'd8}) begin
      errs++; $display("FAIL midreset_rerun got diff %h lat %0d required 1e/8", diff, lat);
    end
  endtask
  task automatic test_width1();
    logic [2:0] c;
    logic [1:0] r;
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      r = 2'({1'b0, c[2]}) - 2'(c[1]) - 2'(c[0]);
      @(negedge clk);
      a1 = c[2]; b1 = c[1]; bi1 = c[0]; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      @(negedge clk);
      vecs++; if ({busy1, done1} !== 2'b10) begin errs++; $display("FAIL w1_run%0d got %b required 10", i, {busy1, done1}); end
      @(negedge clk);
      vecs++;
      if ({done1, bo1, diff1} !== {1'b1, r[1], r[0]}) begin
        errs++; $display("FAIL w1_result%0d got done %b bout %b d %b required 1 %b %b", i, done1, bo1, diff1, r[1], r[0]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_to_back();
    test_mid_run_start();
    test_reset_mid_run();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vecs);
    $fatal(1);
  end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes diff = a - b - borrow_in one bit per clock, LSB first, using a single one-bit full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation counterpart of the team's full adder, and the sequential datapath block that follows the combinational adder/subtractor cells in the arithmetic library.
- It has a start/busy/done handshake, a parallel result, and a serial result stream.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin; sampled only when accepting (IDLE or DONE).
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- borrow_in  input  1  initial borrow; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  parallel difference; held until the next accepted start.
- borrow_out  output  1  final borrow, i.e. unsigned a < b + borrow_in.
- ovf  output  1  signed two's-complement overflow.
- ser_diff  output  1  current serial difference bit.
- ser_valid  output  1  qualifies ser_diff.

Behaviour:
- Reset and clocking
  - Single clock. Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE; busy, done, diff, borrow_out, ovf, ser_diff, ser_valid, the bit counter and the internal shift registers are all 0.
  - Reset asserted mid-operation aborts immediately; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when start=1 at an edge, capture a, b and borrow_in into the shift/borrow registers, clear cnt, go to RUN. When start=0, stay.
  - RUN: each edge processes bit cnt:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
    - shift a and b right; shift d into the result register at the MSB end; cnt++.
    - At the edge with cnt = WIDTH-1, go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back operation) and goes to RUN.
    - Otherwise go to IDLE.
- start while busy=1 is ignored; the captured operands are unaffected.
- Timing (start accepted at edge 0)
  - busy=1 during the cycles after edges 0 through WIDTH-1, i.e. WIDTH cycles.
  - ser_valid=1 during the cycles after edges 1 through WIDTH. In the cycle after edge k+1, ser_diff = bit k of the difference.
  - done=1 during the cycle after edge WIDTH. Latency from start to done is WIDTH cycles.
- Result registers
  - diff, borrow_out and ovf update at the edge entering DONE, and are otherwise held.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands; borrow_in is included in diff.
- Width rules
  - cnt is $clog2(WIDTH)+1 bits wide; there is no wrap-around during RUN.
  - WIDTH=1: RUN lasts one cycle.
- Outputs are registered; there is no combinational input-to-output path.

Decomposition:
- Shared package arith_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - a function for the single-bit difference/borrow equations, so the serial block and a future parallel subtractor use identical logic.
- One natural sub-module: full_subtractor (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once in the RUN datapath.

Test Plan (WIDTH=8 unless noted):
- a=0x5A, b=0x3C, borrow_in=0, start pulse → ser_diff stream LSB-first 0,1,1,1,1,0,0,0; done after 8 cycles; diff=0x1E, borrow_out=0, ovf=0.
- a=0x00, b=0x01, borrow_in=0 → diff=0xFF, borrow_out=1, ovf=0. Then a=0x10, b=0x0F, borrow_in=1 → diff=0x00, borrow_out=0.
- a=0x80, b=0x01 → diff=0x7F, ovf=1, borrow_out=0. Then a=0x7F, b=0xFF → diff=0x80, ovf=1, borrow_out=1.
- Start held high continuously with new operands presented in the DONE cycle → back-to-back operations every 9 cycles; each done is exactly 1 cycle. A start pulse with different operands mid-RUN → ignored, result unchanged.
- rst_n pulsed low asynchronously at RUN cycle 4 → all outputs 0 immediately, no done. The next start runs a correct full operation.
- WIDTH=1: all 8 (a, b, borrow_in) combinations → diff/borrow_out match the full-subtractor truth table; done arrives 1 cycle after start.
